// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, divide length.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_MFHI  = 4'd10,
    OP_MFLO  = 4'd11,
    OP_NOP   = 4'd15
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2
  } mdu_state_e;

  localparam int DIV_CYCLES = 32;

  function automatic logic is_div(mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage to MDU connection. An op commits on a rising edge when
// op_valid=1, ex_stall=0, ex_flush=0 and stall=0; there is no other handshake.
interface mdu_sequencer_if;
  import mdu_pkg::*;

  logic        op_valid;
  mdu_op_e     op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ex_stall;
  logic        ex_flush;
  logic        abort;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  fsm_state;

  modport master (
    output op_valid, op, op_a, op_b, ex_stall, ex_flush, abort,
    input  rd_data, stall, busy, hi, lo, fsm_state
  );

  modport slave (
    input  op_valid, op, op_a, op_b, ex_stall, ex_flush, abort,
    output rd_data, stall, busy, hi, lo, fsm_state
  );
endinterface

// File: rtl/mdu_sequencer_divider.sv
// Iterative restoring divider on operand magnitudes; one quotient bit per step.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        step,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic [5:0]  count_q;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  assign dividend_mag = (is_signed && dividend[31]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;

  // rem_q < divisor always holds, so the shifted value fits in 33 bits.
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, dsr_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      count_q <= '0;
    end else if (start) begin
      quo_q   <= dividend_mag;
      rem_q   <= '0;
      dsr_q   <= divisor_mag;
      count_q <= '0;
    end else if (step && !done) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      count_q <= count_q + 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = (count_q == 6'(DIV_CYCLES));

endmodule

// File: rtl/mdu_sequencer.sv
// MDU sequencer: HILO register, multiply/accumulate, divide FSM with sign fix-up.
module mdu_sequencer
  import mdu_pkg::*;
(
  input logic            clock,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  mdu_state_e  state, state_next;
  logic [4:0]  count, count_next;
  logic [31:0] hi_q, lo_q;
  logic        q_neg, r_neg;
  logic        busy, stall, accept, div_start;
  logic [31:0] div_quo, div_rem, q_fix, r_fix;
  logic        div_done, div_write;
  logic        mac_write;
  logic [63:0] mac_value, hilo, prod_s, prod_u;

  assign busy      = (state != ST_IDLE);
  assign stall     = bus.op_valid & busy & (bus.op != OP_NOP);
  assign accept    = bus.op_valid & ~bus.ex_stall & ~bus.ex_flush & ~stall;
  assign div_start = accept & is_div(bus.op) & (state == ST_IDLE);
  assign hilo      = {hi_q, lo_q};

  mdu_divider u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .is_signed (bus.op == OP_DIV),
    .dividend  (bus.op_a),
    .divisor   (bus.op_b),
    .step      (state == ST_DIV_RUN),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE: if (div_start) begin
        state_next = ST_DIV_RUN;
        count_next = 5'(DIV_CYCLES - 1);
      end
      ST_DIV_RUN: if (count == 5'd0) state_next = ST_DIV_FIX;
                  else count_next = count - 5'd1;
      ST_DIV_FIX: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (busy && bus.abort) begin
      state_next = ST_IDLE;
      count_next = 5'd0;
    end
  end

  // Zero divisor leaves q_neg clear so LO stays all-ones and HI returns op_a.
  assign q_fix     = q_neg ? -div_quo : div_quo;
  assign r_fix     = r_neg ? -div_rem : div_rem;
  assign div_write = (state == ST_DIV_FIX) & ~bus.abort & div_done;

  assign prod_s = $signed(64'($signed(bus.op_a))) * $signed(64'($signed(bus.op_b)));
  assign prod_u = {32'd0, bus.op_a} * {32'd0, bus.op_b};

  always_comb begin
    mac_write = accept;
    mac_value = hilo;
    case (bus.op)
      OP_MULT:  mac_value = prod_s;
      OP_MULTU: mac_value = prod_u;
      OP_MADD:  mac_value = hilo + prod_s;
      OP_MADDU: mac_value = hilo + prod_u;
      OP_MSUB:  mac_value = hilo - prod_s;
      OP_MSUBU: mac_value = hilo - prod_u;
      OP_MTHI:  mac_value = {bus.op_a, lo_q};
      OP_MTLO:  mac_value = {hi_q, bus.op_a};
      default:  mac_write = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= 5'd0;
      hi_q  <= '0;
      lo_q  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (div_start) begin
        q_neg <= (bus.op == OP_DIV) & (bus.op_a[31] ^ bus.op_b[31]) & (bus.op_b != 32'd0);
        r_neg <= (bus.op == OP_DIV) & bus.op_a[31];
      end
      if (div_write) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end else if (mac_write) begin
        hi_q <= mac_value[63:32];
        lo_q <= mac_value[31:0];
      end
    end
  end

  always_comb begin
    bus.rd_data = 32'd0;
    if (bus.op == OP_MFHI) bus.rd_data = hi_q;
    else if (bus.op == OP_MFLO) bus.rd_data = lo_q;
  end

  assign bus.stall     = stall;
  assign bus.busy      = busy;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: divides, stalls, abort/reset, multiply-accumulate.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic [63:0] saved;

  always #5 clock = ~clock;

  mdu_sequencer_if bus();

  mdu_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.op_a     = 32'hDEADBEEF;
    bus.op_b     = 32'd0;
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    bus.abort    = 1'b0;
  endtask

  task automatic issue(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    idle_inputs();
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 60) begin
      cycles++;
      tick();
    end
  endtask

  task automatic div_check(input string tag, input mdu_op_e o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int c;
    issue(o, a, b);
    wait_idle(c);
    check({tag, "_cycles"}, 64'(c), 64'd33);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(2);
    bus.op_valid = 1'b1;
    bus.op = OP_MFHI;
    #1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_stall", {62'd0, bus.busy, bus.stall}, 64'd0);
    check("reset_rd_data", 64'(bus.rd_data), 64'd0);
    check("reset_state", 64'(bus.fsm_state), 64'(ST_IDLE));
    idle_inputs();
    reset = 1'b0;
    tick();

    // Divides: normal, signed, overflow corner, zero divisor.
    div_check("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    div_check("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    div_check("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    div_check("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    div_check("div_m5_by0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // Dependent MFLO stalls through DIV_FIX; a non-HILO op never stalls.
    issue(OP_DIV, 32'hFFFFFF9C, 32'd7);
    tick(2);
    bus.op_valid = 1'b1;
    bus.op = OP_NOP;
    #1;
    check("nop_no_stall", 64'(bus.stall), 64'd0);
    bus.op = OP_MFLO;
    #1;
    check("mflo_stall", 64'(bus.stall), 64'd1);
    n = 0;
    while (bus.stall && n < 60) begin
      n++;
      tick();
    end
    check("mflo_stall_cycles", 64'(n), 64'd31);
    check("mflo_rd_data", 64'(bus.rd_data), 64'hFFFFFFF2);
    check("div_m100_7_hi", 64'(bus.hi), 64'hFFFFFFFE);
    tick();
    idle_inputs();

    // MTHI/MTLO establish a known HILO for the abort cases.
    issue(OP_MTHI, 32'h11111111, 32'd0);
    issue(OP_MTLO, 32'h22222222, 32'd0);
    check("mthi_mtlo", {bus.hi, bus.lo}, 64'h11111111_22222222);

    issue(OP_DIV, 32'd100, 32'd7);
    tick(9);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_run_state", {62'd0, bus.fsm_state}, 64'(ST_IDLE));
    check("abort_run_busy", 64'(bus.busy), 64'd0);
    tick(35);
    check("abort_run_hilo", {bus.hi, bus.lo}, 64'h11111111_22222222);

    issue(OP_DIVU, 32'd100, 32'd7);
    n = 0;
    while (bus.fsm_state != ST_DIV_FIX && n < 40) begin
      n++;
      tick();
    end
    check("reach_fix", 64'(bus.fsm_state), 64'(ST_DIV_FIX));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_fix_state", 64'(bus.fsm_state), 64'(ST_IDLE));
    check("abort_fix_hilo", {bus.hi, bus.lo}, 64'h11111111_22222222);

    // Reset mid-divide clears HILO and discards the divide.
    issue(OP_DIV, 32'd100, 32'd7);
    tick(9);
    reset = 1'b1;
    bus.abort = 1'b1;
    tick();
    reset = 1'b0;
    bus.abort = 1'b0;
    check("reset_mid_state", 64'(bus.fsm_state), 64'(ST_IDLE));
    check("reset_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    tick(35);
    check("reset_mid_hilo_later", {bus.hi, bus.lo}, 64'd0);

    // Multiply and accumulate.
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    check("mult_m1_2", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(OP_MADDU, 32'd1, 32'd1);
    check("maddu_1_1", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFF);
    bus.ex_flush = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5);
    check("mult_flushed", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFF);
    bus.ex_stall = 1'b1;
    bus.op_valid = 1'b1;
    bus.op = OP_DIV;
    bus.op_a = 32'd9;
    bus.op_b = 32'd3;
    tick();
    idle_inputs();
    check("div_ex_stall_busy", 64'(bus.busy), 64'd0);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    check("multu", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
    issue(OP_MSUB, 32'd3, 32'hFFFFFFFF);
    check("msub", {bus.hi, bus.lo}, 64'h00000002_00000001);
    issue(OP_MSUBU, 32'd2, 32'd3);
    check("msubu", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFB);
    issue(OP_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("madd", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFC);
    saved = {bus.hi, bus.lo};
    issue(OP_MSUBU, 32'd0, 32'hFFFFFFFF);
    check("msubu_zero", {bus.hi, bus.lo}, saved);

    bus.op = OP_MFHI;
    #1;
    check("mfhi_rd", 64'(bus.rd_data), 64'h1);
    bus.op = OP_MFLO;
    #1;
    check("mflo_rd", 64'(bus.rd_data), 64'hFFFFFFFC);
    bus.op = OP_NOP;
    #1;
    check("nop_rd", 64'(bus.rd_data), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
